// File: rtl/conv_in_pkg.sv
// rtl/conv_in_pkg.sv - shared config layout, TUSER bit map and FSM state for the conv input tagger
package conv_in_pkg;
  localparam int DEF_KW_MAX      = 7;
  localparam int DEF_SW_MAX      = 2;
  localparam int DEF_BITS_COLS   = 10;
  localparam int DEF_BITS_CIN    = 10;
  localparam int DEF_BITS_BLOCKS = 10;
  // Fields are one bit wider than the legal range so bad configs are representable.
  localparam int DEF_BITS_KW2    = $clog2(DEF_KW_MAX);
  localparam int DEF_BITS_SW     = $clog2(DEF_SW_MAX + 1);

  // Packed MSB first, so kw2 lands in the LSBs of the config word.
  typedef struct packed {
    logic [DEF_BITS_BLOCKS-1:0] blocks_1;
    logic [DEF_BITS_CIN-1:0]    cin_1;
    logic [DEF_BITS_COLS-1:0]   cols_1;
    logic [DEF_BITS_SW-1:0]     sw_1;
    logic [DEF_BITS_KW2-1:0]    kw2;
  } cfg_t;

  localparam int CFG_WIDTH = $bits(cfg_t);

  localparam int I_IS_CONFIG    = 0;
  localparam int I_IS_CIN_LAST  = 1;
  localparam int I_IS_COLS_1_K2 = 2;
  localparam int I_IS_COL_VALID = 3;
  localparam int I_KW2          = 4;
  localparam int I_SW_1         = I_KW2 + DEF_BITS_KW2;
  localparam int TUSER_WIDTH_CONV_IN = I_SW_1 + DEF_BITS_SW;

  typedef enum logic {IDLE, PIX} state_t;
endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - up counter 0..max that wraps to 0, with synchronous clear
module wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic [W-1:0] count,
  output logic         last
);
  assign last = (count == max);

  always_ff @(posedge clk) begin
    if (!rstn)      count <= '0;
    else if (clr)   count <= '0;
    else if (en)    count <= last ? '0 : count + 1'b1;
  end
endmodule

// File: rtl/conv_in_tuser_gen.sv
// rtl/conv_in_tuser_gen.sv - tags conv input beats with config/cin/col TUSER flags for the pad filter
module conv_in_tuser_gen
  import conv_in_pkg::*;
#(
  parameter int DATA_WIDTH  = 64,
  parameter int KW_MAX      = DEF_KW_MAX,
  parameter int SW_MAX      = DEF_SW_MAX,
  parameter int BITS_COLS   = DEF_BITS_COLS,
  parameter int BITS_CIN    = DEF_BITS_CIN,
  parameter int BITS_BLOCKS = DEF_BITS_BLOCKS,
  parameter int TUSER_WIDTH = TUSER_WIDTH_CONV_IN
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic [DATA_WIDTH-1:0]  s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic [TUSER_WIDTH-1:0] m_user,
  output logic [1:0]             err
);
  localparam int KW2_MAX  = KW_MAX / 2;
  localparam int BITS_KW2 = $clog2(KW_MAX);
  localparam int BITS_SW  = $clog2(SW_MAX + 1);
  localparam int O_SW     = BITS_KW2;
  localparam int O_COLS   = O_SW + BITS_SW;
  localparam int O_CIN    = O_COLS + BITS_COLS;
  localparam int O_BLK    = O_CIN + BITS_CIN;

  state_t                 state;
  logic [BITS_KW2-1:0]    kw2_r;
  logic [BITS_SW-1:0]     sw_1_r;
  logic [BITS_COLS-1:0]   cols_1_r;
  logic [BITS_CIN-1:0]    cin_1_r;
  logic [BITS_BLOCKS-1:0] blocks_1_r;
  logic                   bad_cfg_r;
  logic [BITS_SW-1:0]     phase;

  logic [BITS_CIN-1:0]    cin;
  logic [BITS_COLS-1:0]   col;
  logic [BITS_BLOCKS-1:0] blk;
  logic                   cin_last, col_last, blk_last;
  logic                   unused_counts;

  logic                   accept, pix_acc, frame_end, frame_done, col_step;
  logic [BITS_KW2-1:0]    in_kw2;
  logic [BITS_SW-1:0]     in_sw_1;
  logic [BITS_COLS-1:0]   in_cols_1;
  logic [BITS_CIN-1:0]    in_cin_1;
  logic [BITS_BLOCKS-1:0] in_blocks_1;
  logic                   in_bad;
  logic [BITS_COLS-1:0]   k2_col;
  logic [TUSER_WIDTH-1:0] user_nxt;

  assign s_ready    = aclken & (!m_valid | m_ready);
  assign accept     = s_valid & s_ready;
  assign pix_acc    = accept & (state == PIX);
  assign frame_end  = cin_last & col_last & blk_last;
  // An early s_last ends the frame just like the counted final beat.
  assign frame_done = pix_acc & (frame_end | s_last);
  assign col_step   = pix_acc & cin_last;

  assign in_kw2      = s_data[BITS_KW2-1:0];
  assign in_sw_1     = s_data[O_SW +: BITS_SW];
  assign in_cols_1   = s_data[O_COLS +: BITS_COLS];
  assign in_cin_1    = s_data[O_CIN +: BITS_CIN];
  assign in_blocks_1 = s_data[O_BLK +: BITS_BLOCKS];
  assign in_bad      = (in_kw2 > BITS_KW2'(KW2_MAX)) | (in_sw_1 >= BITS_SW'(SW_MAX)) |
                       (in_cols_1 < BITS_COLS'(in_kw2));
  assign k2_col        = cols_1_r - BITS_COLS'(kw2_r);
  assign unused_counts = ^{cin, blk};

  wrap_counter #(.W(BITS_CIN)) u_cin (
    .clk(aclk), .rstn(aresetn), .clr(frame_done), .en(pix_acc),
    .max(cin_1_r), .count(cin), .last(cin_last)
  );
  wrap_counter #(.W(BITS_COLS)) u_col (
    .clk(aclk), .rstn(aresetn), .clr(frame_done), .en(col_step),
    .max(cols_1_r), .count(col), .last(col_last)
  );
  wrap_counter #(.W(BITS_BLOCKS)) u_blk (
    .clk(aclk), .rstn(aresetn), .clr(frame_done), .en(col_step & col_last),
    .max(blocks_1_r), .count(blk), .last(blk_last)
  );

  always_comb begin
    user_nxt = '0;
    if (state == IDLE) begin
      user_nxt[I_IS_CONFIG]          = 1'b1;
      user_nxt[I_KW2 +: BITS_KW2]    = in_kw2;
      user_nxt[I_SW_1 +: BITS_SW]    = in_sw_1;
    end else begin
      user_nxt[I_IS_CIN_LAST]        = cin_last;
      user_nxt[I_IS_COLS_1_K2]       = !bad_cfg_r && (col == k2_col);
      user_nxt[I_IS_COL_VALID]       = (phase == '0);
      user_nxt[I_KW2 +: BITS_KW2]    = kw2_r;
      user_nxt[I_SW_1 +: BITS_SW]    = sw_1_r;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= IDLE;
      m_valid    <= 1'b0;
      m_data     <= '0;
      m_last     <= 1'b0;
      m_user     <= '0;
      err        <= '0;
      kw2_r      <= '0;
      sw_1_r     <= '0;
      cols_1_r   <= '0;
      cin_1_r    <= '0;
      blocks_1_r <= '0;
      bad_cfg_r  <= 1'b0;
      phase      <= '0;
    end else if (aclken) begin
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_last  <= s_last;
        m_user  <= user_nxt;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      if (accept && state == IDLE) begin
        kw2_r      <= in_kw2;
        sw_1_r     <= in_sw_1;
        cols_1_r   <= in_cols_1;
        cin_1_r    <= in_cin_1;
        blocks_1_r <= in_blocks_1;
        bad_cfg_r  <= in_bad;
        if (in_bad) err[0] <= 1'b1;
        state <= PIX;
      end

      if (pix_acc) begin
        if (frame_end != s_last) err[1] <= 1'b1;
        if (frame_done) state <= IDLE;
      end

      // Stride phase restarts at col 0 of every row.
      if (frame_done || (col_step && col_last)) phase <= '0;
      else if (col_step) phase <= (phase == sw_1_r) ? '0 : phase + 1'b1;
    end
  end
endmodule
